// File: rtl/pkt_dispatch.sv
// Requests one packet at a time from the packet cache and re-times the returned words and end-of-packet flag to transmit.
// Optional statistics counters are built when PKT_DISPATCH_STAT_EN is defined.
module pkt_dispatch #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_pkt_dispatch_ID,
  input  logic [4:0]   in_pkt_dispatch_ID_count,
  output logic [7:0]   out_pkt_dispatch_ID,
  output logic         out_pkt_dispatch_ID_wr,
  input  logic         in_pkt_dispatch_data_wr,
  input  logic [133:0] in_pkt_dispatch_data,
  input  logic         in_pkt_dispatch_valid_wr,
  input  logic         in_pkt_dispatch_valid,
  output logic         out_pkt_dispatch_data_wr,
  output logic [133:0] out_pkt_dispatch_data,
  output logic         out_pkt_dispatch_valid_wr,
  output logic         out_pkt_dispatch_valid,
  input  logic         in_pkt_dispatch_alf
`ifdef PKT_DISPATCH_STAT_EN
  ,
  output logic [31:0]  out_pkt_dispatch_pkt_cnt,
  output logic [31:0]  out_pkt_dispatch_err_cnt
`endif
);

  localparam int unsigned DATA_W = 134;
  localparam int unsigned ID_W   = 8;
  localparam int unsigned TMO_W  = 10;
  localparam logic [1:0]  HEAD   = 2'b01;
  localparam logic [1:0]  TAIL   = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_PKT = 2'd1,
    GAP      = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                seen_word_q, seen_word_d;
  logic                seen_tail_q, seen_tail_d;
  logic                ferr_q, ferr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                id_wr_q, id_wr_d;
  logic                data_wr_q, data_wr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_wr_q, valid_wr_d;
  logic                valid_q, valid_d;
  logic [1:0]          word_type;

  assign word_type = in_pkt_dispatch_data[DATA_W-1 -: 2];

  // Request, frame check, forwarding and timeout
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    seen_word_d = seen_word_q;
    seen_tail_d = seen_tail_q;
    ferr_d      = ferr_q;
    id_d        = id_q;
    id_wr_d     = 1'b0;
    data_wr_d   = 1'b0;
    data_d      = data_q;
    valid_wr_d  = 1'b0;
    valid_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if ((in_pkt_dispatch_ID_count != 5'd0) && !in_pkt_dispatch_alf) begin
          id_d        = in_pkt_dispatch_ID;
          id_wr_d     = 1'b1;
          tmo_d       = '0;
          ferr_d      = 1'b0;
          seen_word_d = 1'b0;
          seen_tail_d = 1'b0;
          state_d     = WAIT_PKT;
        end
      end
      WAIT_PKT: begin
        if (in_pkt_dispatch_data_wr) begin
          data_wr_d = 1'b1;
          data_d    = in_pkt_dispatch_data;
          if (!seen_word_q) begin
            if (word_type != HEAD) ferr_d = 1'b1;
          end else if (word_type == HEAD) begin
            ferr_d = 1'b1;
          end
          if (seen_tail_q) ferr_d = 1'b1;
          if (word_type == TAIL) seen_tail_d = 1'b1;
          seen_word_d = 1'b1;
        end
        // A same-cycle word is already folded into ferr_d/seen_tail_d here
        if (in_pkt_dispatch_valid_wr) begin
          valid_wr_d = 1'b1;
          valid_d    = in_pkt_dispatch_valid & ~ferr_d & seen_tail_d;
          state_d    = GAP;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          valid_wr_d = 1'b1;
          valid_d    = 1'b0;
          state_d    = GAP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      seen_word_q <= 1'b0;
      seen_tail_q <= 1'b0;
      ferr_q      <= 1'b0;
      id_q        <= '0;
      id_wr_q     <= 1'b0;
      data_wr_q   <= 1'b0;
      data_q      <= '0;
      valid_wr_q  <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      seen_word_q <= seen_word_d;
      seen_tail_q <= seen_tail_d;
      ferr_q      <= ferr_d;
      id_q        <= id_d;
      id_wr_q     <= id_wr_d;
      data_wr_q   <= data_wr_d;
      data_q      <= data_d;
      valid_wr_q  <= valid_wr_d;
      valid_q     <= valid_d;
    end
  end

  assign out_pkt_dispatch_ID       = id_q;
  assign out_pkt_dispatch_ID_wr    = id_wr_q;
  assign out_pkt_dispatch_data_wr  = data_wr_q;
  assign out_pkt_dispatch_data     = data_q;
  assign out_pkt_dispatch_valid_wr = valid_wr_q;
  assign out_pkt_dispatch_valid    = valid_q;

`ifdef PKT_DISPATCH_STAT_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;

  // Counters advance on the same edge the end-of-packet strobe is issued
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (valid_wr_d) begin
      if (valid_d) pkt_cnt_d = pkt_cnt_q + 32'd1;
      else         err_cnt_d = err_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_pkt_dispatch_pkt_cnt = pkt_cnt_q;
  assign out_pkt_dispatch_err_cnt = err_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pkt_dispatch.sv
// Self-checking bench for pkt_dispatch: packet-level reference model plus directed cache-side vectors.
// Statistics checks are compiled when PKT_DISPATCH_STAT_EN is defined.
module tb_pkt_dispatch;

  localparam int unsigned TMO = 16;
  localparam logic [1:0]  H   = 2'b01;
  localparam logic [1:0]  M   = 2'b11;
  localparam logic [1:0]  T   = 2'b10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [7:0]   in_pkt_dispatch_ID = '0;
  logic [4:0]   in_pkt_dispatch_ID_count = '0;
  logic [7:0]   out_pkt_dispatch_ID;
  logic         out_pkt_dispatch_ID_wr;
  logic         in_pkt_dispatch_data_wr = 1'b0;
  logic [133:0] in_pkt_dispatch_data = '0;
  logic         in_pkt_dispatch_valid_wr = 1'b0;
  logic         in_pkt_dispatch_valid = 1'b0;
  logic         out_pkt_dispatch_data_wr;
  logic [133:0] out_pkt_dispatch_data;
  logic         out_pkt_dispatch_valid_wr;
  logic         out_pkt_dispatch_valid;
  logic         in_pkt_dispatch_alf = 1'b0;
`ifdef PKT_DISPATCH_STAT_EN
  logic [31:0]  out_pkt_dispatch_pkt_cnt;
  logic [31:0]  out_pkt_dispatch_err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int req_seen = 0;
  logic [31:0] seq = 32'd1;

  always #5 clk = ~clk;

  pkt_dispatch #(.TIMEOUT(TMO)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .in_pkt_dispatch_ID        (in_pkt_dispatch_ID),
    .in_pkt_dispatch_ID_count  (in_pkt_dispatch_ID_count),
    .out_pkt_dispatch_ID       (out_pkt_dispatch_ID),
    .out_pkt_dispatch_ID_wr    (out_pkt_dispatch_ID_wr),
    .in_pkt_dispatch_data_wr   (in_pkt_dispatch_data_wr),
    .in_pkt_dispatch_data      (in_pkt_dispatch_data),
    .in_pkt_dispatch_valid_wr  (in_pkt_dispatch_valid_wr),
    .in_pkt_dispatch_valid     (in_pkt_dispatch_valid),
    .out_pkt_dispatch_data_wr  (out_pkt_dispatch_data_wr),
    .out_pkt_dispatch_data     (out_pkt_dispatch_data),
    .out_pkt_dispatch_valid_wr (out_pkt_dispatch_valid_wr),
    .out_pkt_dispatch_valid    (out_pkt_dispatch_valid),
    .in_pkt_dispatch_alf       (in_pkt_dispatch_alf)
`ifdef PKT_DISPATCH_STAT_EN
    ,
    .out_pkt_dispatch_pkt_cnt  (out_pkt_dispatch_pkt_cnt),
    .out_pkt_dispatch_err_cnt  (out_pkt_dispatch_err_cnt)
`endif
  );

  // Reference model: a request is outstanding, its words are collected, and the whole frame is judged at the end
  logic [7:0]   exp_id;
  logic         exp_id_wr, exp_data_wr, exp_valid_wr, exp_valid;
  logic [133:0] exp_data;
  logic [31:0]  exp_pkt_cnt, exp_err_cnt;
  bit           outstanding;
  int           age, holdoff;
  logic [1:0]   frame[$];

  function automatic bit frame_ok();
    int last = frame.size() - 1;
    if (frame.size() == 0) return 1'b0;
    if (frame[0] != H || frame[last] != T) return 1'b0;
    for (int i = 0; i < last; i++) if (frame[i] == T) return 1'b0;
    for (int i = 1; i <= last; i++) if (frame[i] == H) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_id = '0; exp_id_wr = 0; exp_data_wr = 0; exp_data = '0;
      exp_valid_wr = 0; exp_valid = 0; exp_pkt_cnt = '0; exp_err_cnt = '0;
      outstanding = 0; age = 0; holdoff = 0; frame.delete();
    end else begin
      exp_id_wr = 0; exp_data_wr = 0; exp_valid_wr = 0; exp_valid = 0;
      if (outstanding) begin
        age++;
        if (in_pkt_dispatch_data_wr) begin
          exp_data_wr = 1;
          exp_data    = in_pkt_dispatch_data;
          frame.push_back(in_pkt_dispatch_data[133:132]);
        end
        if (in_pkt_dispatch_valid_wr) begin
          exp_valid_wr = 1;
          exp_valid    = in_pkt_dispatch_valid && frame_ok();
          outstanding  = 0;
          holdoff      = 1;
        end else if (age == int'(TMO)) begin
          exp_valid_wr = 1;
          outstanding  = 0;
          holdoff      = 1;
        end
      end else if (holdoff > 0) begin
        holdoff--;
      end else if (in_pkt_dispatch_ID_count != 0 && !in_pkt_dispatch_alf) begin
        exp_id_wr   = 1;
        exp_id      = in_pkt_dispatch_ID;
        outstanding = 1;
        age         = 0;
        frame.delete();
      end
      if (exp_valid_wr) begin
        if (exp_valid) exp_pkt_cnt++;
        else           exp_err_cnt++;
      end
    end
  end

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    check("id",       134'(out_pkt_dispatch_ID),       134'(exp_id));
    check("id_wr",    134'(out_pkt_dispatch_ID_wr),    134'(exp_id_wr));
    check("data_wr",  134'(out_pkt_dispatch_data_wr),  134'(exp_data_wr));
    check("valid_wr", 134'(out_pkt_dispatch_valid_wr), 134'(exp_valid_wr));
    if (exp_data_wr)  check("data",  out_pkt_dispatch_data, exp_data);
    if (exp_valid_wr) check("valid", 134'(out_pkt_dispatch_valid), 134'(exp_valid));
`ifdef PKT_DISPATCH_STAT_EN
    check("pkt_cnt", 134'(out_pkt_dispatch_pkt_cnt), 134'(exp_pkt_cnt));
    check("err_cnt", 134'(out_pkt_dispatch_err_cnt), 134'(exp_err_cnt));
`endif
    if (out_pkt_dispatch_ID_wr) req_seen++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Present an ID/count and wait for the request strobe, then apply the post-dequeue count
  task automatic request(input logic [7:0] id, input logic [4:0] cnt_before,
                         input logic [4:0] cnt_after, output int waited);
    in_pkt_dispatch_ID       = id;
    in_pkt_dispatch_ID_count = cnt_before;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!out_pkt_dispatch_ID_wr && waited < 64);
    if (!out_pkt_dispatch_ID_wr) begin
      checks++;
      errors++;
      $display("FAIL req_wait: no ID_wr for ID %h within %0d cycles", id, waited);
    end else begin
      check("req_id", 134'(out_pkt_dispatch_ID), 134'(id));
    end
    in_pkt_dispatch_ID_count = cnt_after;
  endtask

  // Send n words whose types are packed first-word-lowest in t; close with valid_wr (merged onto last word if asked)
  task automatic send(input int n, input logic [15:0] t, input bit vld, input bit merge);
    for (int i = 0; i < n; i++) begin
      in_pkt_dispatch_data_wr  = 1'b1;
      in_pkt_dispatch_data     = {t[2*i +: 2], 100'h0, seq};
      seq                      = seq + 32'd1;
      in_pkt_dispatch_valid_wr = merge && (i == n - 1);
      in_pkt_dispatch_valid    = vld;
      tick();
    end
    in_pkt_dispatch_data_wr = 1'b0;
    if (!merge) begin
      in_pkt_dispatch_valid_wr = 1'b1;
      in_pkt_dispatch_valid    = vld;
      tick();
    end
    in_pkt_dispatch_valid_wr = 1'b0;
    in_pkt_dispatch_valid    = 1'b0;
  endtask

  int          tn[6];
  logic [15:0] tt[6];
  bit          tv[6];
  bit          te[6];

  initial begin
    int w;
    int n;
    int base;
    tn[0] = 3; tt[0] = 16'({M, T, H});    tv[0] = 1; te[0] = 0;
    tn[1] = 3; tt[1] = 16'({T, H, H});    tv[1] = 1; te[1] = 0;
    tn[2] = 3; tt[2] = 16'({T, M, H});    tv[2] = 0; te[2] = 0;
    tn[3] = 3; tt[3] = 16'({T, 2'b00, H}); tv[3] = 1; te[3] = 1;
    tn[4] = 1; tt[4] = 16'(T);            tv[4] = 1; te[4] = 0;
    tn[5] = 2; tt[5] = 16'({M, H});       tv[5] = 1; te[5] = 0;

    #2 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_id",       134'(out_pkt_dispatch_ID),       134'(8'h00));
    check("rst_valid_wr", 134'(out_pkt_dispatch_valid_wr), 134'(0));
    rst_n = 1'b1;
    tick();

    // Single good packet
    request(8'h05, 5'd1, 5'd0, w);
    send(3, 16'({T, M, H}), 1'b1, 1'b0);
    check("good_valid_wr", 134'(out_pkt_dispatch_valid_wr), 134'(1));
    check("good_valid",    134'(out_pkt_dispatch_valid),    134'(1));
`ifdef PKT_DISPATCH_STAT_EN
    check("good_pkt_cnt",  134'(out_pkt_dispatch_pkt_cnt),  134'(32'd1));
`endif

    // Backpressure holds requests; alf mid-packet does not stall forwarding
    in_pkt_dispatch_alf      = 1'b1;
    in_pkt_dispatch_ID_count = 5'd3;
    in_pkt_dispatch_ID       = 8'h11;
    base = req_seen;
    repeat (20) tick();
    check("alf_hold", 134'(req_seen - base), 134'(0));
    in_pkt_dispatch_alf = 1'b0;
    request(8'h11, 5'd3, 5'd0, w);
    check("alf_latency", 134'(w), 134'(1));
    in_pkt_dispatch_alf = 1'b1;
    send(4, 16'({T, M, M, H}), 1'b1, 1'b0);
    check("alf_pkt_valid", 134'(out_pkt_dispatch_valid), 134'(1));
    in_pkt_dispatch_alf = 1'b0;

    // Missing head
    request(8'h22, 5'd1, 5'd0, w);
    send(2, 16'({T, M}), 1'b1, 1'b0);
    check("nohead_valid_wr", 134'(out_pkt_dispatch_valid_wr), 134'(1));
    check("nohead_valid",    134'(out_pkt_dispatch_valid),    134'(0));
`ifdef PKT_DISPATCH_STAT_EN
    check("nohead_err_cnt",  134'(out_pkt_dispatch_err_cnt),  134'(32'd1));
`endif

    // Frame-structure table
    for (int i = 0; i < 6; i++) begin
      request(8'h70 + 8'(i), 5'd1, 5'd0, w);
      send(tn[i], tt[i], tv[i], 1'b0);
      check("table_valid", 134'(out_pkt_dispatch_valid), 134'(te[i]));
    end

    // Timeout with no cache response, then stray words are dropped
    request(8'h33, 5'd1, 5'd0, w);
    n = 0;
    while (!out_pkt_dispatch_valid_wr && n < 40) begin
      tick();
      n++;
    end
    check("tmo_cycles", 134'(n), 134'(16));
    check("tmo_valid",  134'(out_pkt_dispatch_valid), 134'(0));
    in_pkt_dispatch_data_wr  = 1'b1;
    in_pkt_dispatch_data     = {H, 132'h5a5};
    in_pkt_dispatch_valid_wr = 1'b1;
    in_pkt_dispatch_valid    = 1'b1;
    in_pkt_dispatch_ID_count = 5'd1;
    in_pkt_dispatch_ID       = 8'h34;
    tick();
    in_pkt_dispatch_data_wr  = 1'b0;
    in_pkt_dispatch_valid_wr = 1'b0;
    in_pkt_dispatch_valid    = 1'b0;
    check("stray_data_wr",  134'(out_pkt_dispatch_data_wr),  134'(0));
    check("stray_valid_wr", 134'(out_pkt_dispatch_valid_wr), 134'(0));
    request(8'h34, 5'd1, 5'd0, w);
    check("post_tmo_req", 134'(w), 134'(1));
    send(3, 16'({T, M, H}), 1'b1, 1'b0);

    // valid_wr on the expiry cycle wins and is judged normally
    request(8'h40, 5'd1, 5'd0, w);
    in_pkt_dispatch_data_wr = 1'b1;
    in_pkt_dispatch_data    = {H, 132'h1};
    tick();
    in_pkt_dispatch_data    = {T, 132'h2};
    tick();
    in_pkt_dispatch_data_wr = 1'b0;
    repeat (13) tick();
    in_pkt_dispatch_valid_wr = 1'b1;
    in_pkt_dispatch_valid    = 1'b1;
    tick();
    in_pkt_dispatch_valid_wr = 1'b0;
    in_pkt_dispatch_valid    = 1'b0;
    check("race_valid_wr", 134'(out_pkt_dispatch_valid_wr), 134'(1));
    check("race_valid",    134'(out_pkt_dispatch_valid),    134'(1));

    // Back-to-back packets, first closed with valid_wr merged on its tail word
    request(8'h50, 5'd2, 5'd1, w);
    send(4, 16'({T, M, M, H}), 1'b1, 1'b1);
    check("b2b_valid", 134'(out_pkt_dispatch_valid), 134'(1));
    in_pkt_dispatch_ID = 8'h51;
    n = 0;
    while (!out_pkt_dispatch_ID_wr && n < 20) begin
      tick();
      n++;
    end
    check("b2b_gap", 134'(n), 134'(2));
    check("b2b_id",  134'(out_pkt_dispatch_ID), 134'(8'h51));
    in_pkt_dispatch_ID_count = 5'd0;
    send(4, 16'({T, M, M, H}), 1'b1, 1'b0);

    // Reset after the second word
    request(8'h60, 5'd1, 5'd0, w);
    in_pkt_dispatch_data_wr = 1'b1;
    in_pkt_dispatch_data    = {H, 132'h10};
    tick();
    in_pkt_dispatch_data    = {M, 132'h11};
    tick();
    in_pkt_dispatch_data_wr = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_data_wr",  134'(out_pkt_dispatch_data_wr),  134'(0));
    check("mrst_data",     out_pkt_dispatch_data,           134'(0));
    check("mrst_valid_wr", 134'(out_pkt_dispatch_valid_wr), 134'(0));
    check("mrst_id",       134'(out_pkt_dispatch_ID),       134'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    request(8'h61, 5'd1, 5'd0, w);
    check("mrst_req", 134'(w), 134'(1));
    send(3, 16'({T, M, H}), 1'b1, 1'b0);
`ifdef PKT_DISPATCH_STAT_EN
    check("mrst_pkt_cnt", 134'(out_pkt_dispatch_pkt_cnt), 134'(32'd1));
`endif
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_dispatch.md
# pkt_dispatch

Downstream consumer of the packet data cache. Watches the cache's buffered-packet ID and count, requests one packet at a time by writing its ID back to the cache, and re-times the returned 134-bit packet words and end-of-packet valid flag towards the transmit port. Honours transmit-side almost-full backpressure between packets, checks frame structure, and recovers from a missing cache response by timeout.

## Interface

- TIMEOUT, 1023: cycles allowed from ID request to cache end-of-packet valid; 10-bit counter, legal range 16..1023.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_pkt_dispatch_ID  in  8  head-of-queue packet ID from cache
- in_pkt_dispatch_ID_count  in  5  packets currently buffered in cache
- out_pkt_dispatch_ID  out  8  ID requested from cache
- out_pkt_dispatch_ID_wr  out  1  one-cycle request strobe
- in_pkt_dispatch_data_wr  in  1  cache data word strobe
- in_pkt_dispatch_data  in  134  cache data word; [133:132] = 01 head, 11 middle, 10 tail
- in_pkt_dispatch_valid_wr  in  1  cache end-of-packet strobe
- in_pkt_dispatch_valid  in  1  cache packet-good flag
- out_pkt_dispatch_data_wr  out  1  data word strobe to transmit
- out_pkt_dispatch_data  out  134  data word to transmit
- out_pkt_dispatch_valid_wr  out  1  end-of-packet strobe to transmit
- out_pkt_dispatch_valid  out  1  1 = keep packet, 0 = discard
- in_pkt_dispatch_alf  in  1  transmit FIFO almost full
- out_pkt_dispatch_pkt_cnt  out  32  forwarded good packets (PKT_DISPATCH_STAT_EN only)
- out_pkt_dispatch_err_cnt  out  32  discarded/timed-out packets (PKT_DISPATCH_STAT_EN only)

## Operation

- States: IDLE, WAIT_PKT, GAP.
- IDLE: when in_pkt_dispatch_ID_count != 0 and in_pkt_dispatch_alf = 0, drive out_pkt_dispatch_ID = in_pkt_dispatch_ID, pulse out_pkt_dispatch_ID_wr for one cycle, clear timeout counter, clear frame-error flag, go WAIT_PKT.
- WAIT_PKT: every in data_wr is forwarded (data registered unchanged). The frame checker tracks a seen-head bit:
  - error if the first word is not 01;
  - error if a 01 appears after the head;
  - error if any word arrives after a 10.
- WAIT_PKT exit on in valid_wr: forward valid_wr, with out valid = in valid AND no frame error AND a tail was seen. Go GAP.
- Timeout: counter increments each WAIT_PKT cycle. When it reaches TIMEOUT without valid_wr, emit out valid_wr = 1 with out valid = 0 (synthesised discard), go GAP. Any later stray cache words or valid_wr seen in IDLE/GAP are dropped and not forwarded.
- GAP: exactly one cycle, then IDLE. This lets the cache update its ID/count before the next request.
- alf is sampled only in IDLE. A packet already requested is forwarded in full regardless of alf.
- ID_count is treated as unsigned. A value of 0 never issues a request.
- Reset mid-packet: all state is discarded. The first cycle after rst_n deasserts is IDLE. No partial packet end is emitted.

## Timing

- Reset values:
  - all outputs 0;
  - out_pkt_dispatch_ID = 8'h00;
  - counters 0.
- Request: ID_wr is asserted the cycle after IDLE sees count != 0 and alf = 0, i.e. registered with 1-cycle latency.
- Data and valid path: exactly 1-cycle register latency, in to out, with no bubbles inserted and word order preserved.
- Minimum request-to-request spacing is the packet length plus 2 cycles after the cache valid_wr (1 forward + 1 GAP).
- Simultaneous data_wr and valid_wr on the same cycle: the word is included in the frame check, then the packet is closed.
- Simultaneous timeout expiry and valid_wr: valid_wr wins, and the packet is judged normally.

## Configuration

- PKT_DISPATCH_STAT_EN defined:
  - pkt_cnt increments on each forwarded valid_wr with valid = 1;
  - err_cnt increments on each forwarded valid_wr with valid = 0 (frame error, cache-flagged bad, or timeout);
  - both counters wrap at 2^32.
- Not defined: both counter ports are absent and no counter logic is built. Data-path behaviour is identical in both builds.

## Test plan

- Single good packet: count = 1, ID = 8'h05, cache returns 01/11/10 then valid_wr with valid = 1 -> ID_wr pulse carrying 05, three words out 1 cycle later, valid_wr with valid = 1, pkt_cnt = 1.
- Backpressure: count = 3, alf = 1 for 20 cycles -> no ID_wr. Drop alf -> first request 1 cycle later; alf raised mid-packet does not stall forwarding.
- Malformed frame: cache sends 11/10 (no head) with valid = 1 -> both words forwarded, out valid = 0, err_cnt = 1.
- Timeout: TIMEOUT = 16, cache never responds -> out valid_wr with valid = 0 on cycle 16 of WAIT_PKT. A late cache valid_wr is not forwarded. The next request follows after GAP.
- Back-to-back packets: count = 2, two 4-word packets -> second ID_wr occurs 2 cycles after the first valid_wr, with no word loss and no reordering.
- Reset mid-packet: rst_n low after the 2nd word -> all outputs 0 immediately, no valid_wr emitted, IDLE after release.
